// File: rtl/btb_2way_predictor.sv
// Two-way set-associative branch target buffer with 2-bit direction counters.
// Lookup is combinational from the stored state. The resolved-branch write happens on the clock edge.
module btb_2way_predictor #(
    parameter int         SETS_LOG2 = 4,
    parameter int         ADDR_W    = 32,
    parameter logic [1:0] CNT_INIT  = 2'b10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              inv_en
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = ADDR_W - SETS_LOG2 - 2;

    logic [SETS_LOG2-1:0] fetch_idx;
    logic [SETS_LOG2-1:0] upd_idx;
    logic [TAG_W-1:0]     fetch_tag;
    logic [TAG_W-1:0]     upd_tag;

    assign fetch_idx = fetch_pc[SETS_LOG2+1:2];
    assign fetch_tag = fetch_pc[ADDR_W-1:SETS_LOG2+2];
    assign upd_idx   = upd_pc[SETS_LOG2+1:2];
    assign upd_tag   = upd_pc[ADDR_W-1:SETS_LOG2+2];

    // Instruction-alignment bits never take part in indexing or tag compare.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

    logic [1:0]        fetch_hit;
    logic [1:0]        upd_hit;
    logic [1:0]        upd_valid;
    logic [1:0]        fetch_cnt [2];
    logic [ADDR_W-1:0] fetch_tgt [2];
    logic [1:0]        clr_en;
    logic [1:0]        train_en;
    logic [1:0]        alloc_en;

    logic lru_reg [SETS];
    logic upd_act;
    logic upd_any_hit;
    logic victim;

    // Invalidation outranks an update issued in the same cycle.
    assign upd_act     = upd_en && !inv_en;
    assign upd_any_hit = |upd_hit;

    always_comb begin
        victim = 1'b0;
        if (!upd_valid[0]) begin
            victim = 1'b0;
        end else if (!upd_valid[1]) begin
            victim = 1'b1;
        end else begin
            victim = lru_reg[upd_idx];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            localparam logic WAY_ID = (gi == 1);

            logic              valid_reg  [SETS];
            logic [1:0]        cnt_reg    [SETS];
            logic [TAG_W-1:0]  tag_reg    [SETS];
            logic [ADDR_W-1:0] target_reg [SETS];
            logic [1:0]        cnt_cur;
            logic [1:0]        cnt_next;

            assign fetch_hit[gi] = valid_reg[fetch_idx] && (tag_reg[fetch_idx] == fetch_tag);
            assign fetch_cnt[gi] = cnt_reg[fetch_idx];
            assign fetch_tgt[gi] = target_reg[fetch_idx];

            assign upd_valid[gi] = valid_reg[upd_idx];
            assign upd_hit[gi]   = upd_valid[gi] && (tag_reg[upd_idx] == upd_tag);

            assign clr_en[gi]   = inv_en && upd_hit[gi];
            assign train_en[gi] = upd_act && upd_hit[gi];
            assign alloc_en[gi] = upd_act && !upd_any_hit && upd_taken && (victim == WAY_ID);

            // Saturating 2-bit counter step.
            assign cnt_cur = cnt_reg[upd_idx];
            always_comb begin
                cnt_next = cnt_cur;
                if (upd_taken) begin
                    if (cnt_cur != 2'd3) begin
                        cnt_next = cnt_cur + 2'd1;
                    end
                end else begin
                    if (cnt_cur != 2'd0) begin
                        cnt_next = cnt_cur - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        valid_reg[s] <= 1'b0;
                        cnt_reg[s]   <= 2'd0;
                    end
                end else if (clr_en[gi]) begin
                    valid_reg[upd_idx] <= 1'b0;
                end else if (alloc_en[gi]) begin
                    valid_reg[upd_idx] <= 1'b1;
                    cnt_reg[upd_idx]   <= CNT_INIT;
                end else if (train_en[gi]) begin
                    cnt_reg[upd_idx] <= cnt_next;
                end
            end

            // Tag and target carry no reset; valid gates every use of them.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    if (alloc_en[gi]) begin
                        tag_reg[upd_idx]    <= upd_tag;
                        target_reg[upd_idx] <= upd_target;
                    end else if (train_en[gi] && upd_taken) begin
                        target_reg[upd_idx] <= upd_target;
                    end
                end
            end
        end
    endgenerate

    // The LRU bit names the way to evict next.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                lru_reg[s] <= 1'b0;
            end
        end else if (upd_act) begin
            if (upd_any_hit) begin
                lru_reg[upd_idx] <= !upd_hit[1];
            end else if (upd_taken) begin
                lru_reg[upd_idx] <= !victim;
            end
        end
    end

    logic sel_way;
    assign sel_way     = fetch_hit[1];
    assign pred_hit    = |fetch_hit;
    assign pred_taken  = pred_hit && fetch_cnt[sel_way][1];
    assign pred_target = pred_hit ? fetch_tgt[sel_way] : '0;

endmodule
